sram_port_arbiter: RTL and testbench

- Shares one single-port, synchronous-read block RAM (1-cycle read latency, write-through on write) between two requesters.
- Requester 0 is the VGA display pixel fetch (read-only, latency-sensitive).
- Requester 1 is the game-logic engine (read or write, e.g. snake/button sprite updates).
- Sits between those two clients and the RAM instance.
- Issues at most one access per cycle, prioritising the display with a bounded-starvation guarantee for game logic, and routes read data back to the owner.

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/sram_arb_starve_cnt.sv | 38 +++
 rtl/sram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-client block-RAM port arbiter.
// Owner encoding, response-tag layout and starvation counter helpers.
package sram_arb_pkg;

   localparam logic OWNER_DISP = 1'b0;
   localparam logic OWNER_GAME = 1'b1;

   localparam int STARVE_CNT_W = 8;

   typedef struct packed {
      logic is_read;
      logic owner;
   } rsp_tag_t;

   localparam int RSP_TAG_W = $bits(rsp_tag_t);

   localparam rsp_tag_t RSP_TAG_IDLE = '{is_read: 1'b0, owner: OWNER_DISP};

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STARVE_CNT_W-1:0] sat_inc(input logic [STARVE_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Counts consecutive cycles the game client waits; raises force_game at the limit.
// Zero latency on force_game (driven from the count register); no backpressure.
module sram_arb_starve_cnt
   import sram_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic game_req,
   input  logic game_gnt,
   output logic force_game
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] cnt_q;
   logic [STARVE_CNT_W-1:0] cnt_d;

   // An idle or served game client owes nothing, so the wait restarts.
   always_comb begin
      cnt_d = sat_inc(cnt_q);
      if (!game_req || game_gnt) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_game = game_req && (cnt_q >= LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sync-read RAM between display (priority) and game (starvation-bounded).
// Grant is combinational, read data returns two cycles after grant; losers hold req.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 16,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,

   input  logic                  disp_req,
   input  logic [ADDR_WIDTH-1:0] disp_addr,
   output logic                  disp_gnt,
   output logic                  disp_rvalid,
   output logic [DATA_WIDTH-1:0] disp_rdata,

   input  logic                  game_req,
   input  logic                  game_we,
   input  logic [ADDR_WIDTH-1:0] game_addr,
   input  logic [DATA_WIDTH-1:0] game_wdata,
   output logic                  game_gnt,
   output logic                  game_rvalid,
   output logic [DATA_WIDTH-1:0] game_rdata,

   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   logic force_game;
   logic game_win;
   logic disp_win;

   // Grants are masked in reset so the outputs read zero while reset_n is low.
   always_comb begin
      game_win = reset_n && game_req && (!disp_req || force_game);
      disp_win = reset_n && disp_req && !game_win;
   end

   assign game_gnt = game_win;
   assign disp_gnt = disp_win;

   sram_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .game_req   (game_req),
      .game_gnt   (game_win),
      .force_game (force_game)
   );

   logic                  mem_en_q,    mem_en_d;
   logic                  mem_we_q,    mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   always_comb begin
      mem_en_d    = game_win || disp_win;
      mem_we_d    = game_win && game_we;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (game_win) begin
         mem_addr_d  = game_addr;
         mem_wdata_d = game_wdata;
      end else if (disp_win) begin
         mem_addr_d  = disp_addr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Stage 1 is aligned with the RAM command, stage 2 with the RAM output.
   rsp_tag_t rsp1_q, rsp1_d;
   rsp_tag_t rsp2_q, rsp2_d;

   always_comb begin
      rsp1_d         = RSP_TAG_IDLE;
      rsp1_d.is_read = mem_en_d && !mem_we_d;
      rsp1_d.owner   = game_win ? OWNER_GAME : OWNER_DISP;
      rsp2_d         = rsp1_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp1_q <= RSP_TAG_IDLE;
         rsp2_q <= RSP_TAG_IDLE;
      end else begin
         rsp1_q <= rsp1_d;
         rsp2_q <= rsp2_d;
      end
   end

   logic disp_hit;
   logic game_hit;

   assign disp_hit    = rsp2_q.is_read && (rsp2_q.owner == OWNER_DISP);
   assign game_hit    = rsp2_q.is_read && (rsp2_q.owner == OWNER_GAME);
   assign disp_rvalid = disp_hit;
   assign game_rvalid = game_hit;

   // RAM output passes straight through on the owner's valid cycle and is
   // captured so each client keeps seeing its last word between responses.
   logic [DATA_WIDTH-1:0] disp_rdata_q, disp_rdata_d;
   logic [DATA_WIDTH-1:0] game_rdata_q, game_rdata_d;

   always_comb begin
      disp_rdata_d = disp_rdata_q;
      game_rdata_d = game_rdata_q;
      if (disp_hit) begin
         disp_rdata_d = mem_rdata;
      end
      if (game_hit) begin
         game_rdata_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         disp_rdata_q <= '0;
         game_rdata_q <= '0;
      end else begin
         disp_rdata_q <= disp_rdata_d;
         game_rdata_q <= game_rdata_d;
      end
   end

   assign disp_rdata = disp_rdata_d;
   assign game_rdata = game_rdata_d;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter with a behavioural RAM and
// a transaction-level reference (wait counter, shadow memory, response queue).
module tb_sram_port_arbiter;

   localparam int LIMIT = 15;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        disp_req;
   logic [15:0] disp_addr;
   logic        disp_gnt;
   logic        disp_rvalid;
   logic [7:0]  disp_rdata;
   logic        game_req;
   logic        game_we;
   logic [15:0] game_addr;
   logic [7:0]  game_wdata;
   logic        game_gnt;
   logic        game_rvalid;
   logic [7:0]  game_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   always #5 clk = ~clk;

   sram_port_arbiter #(
      .DATA_WIDTH   (8),
      .ADDR_WIDTH   (16),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .disp_req    (disp_req),
      .disp_addr   (disp_addr),
      .disp_gnt    (disp_gnt),
      .disp_rvalid (disp_rvalid),
      .disp_rdata  (disp_rdata),
      .game_req    (game_req),
      .game_we     (game_we),
      .game_addr   (game_addr),
      .game_wdata  (game_wdata),
      .game_gnt    (game_gnt),
      .game_rvalid (game_rvalid),
      .game_rdata  (game_rdata),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   function automatic logic [7:0] mem_init(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hB5;
   endfunction

   // Block RAM: 1-cycle read, write data echoed on the output.
   logic [7:0] ram [0:65535];
   bit         ram_ready;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 65536; i++) ram[i] <= mem_init(16'(i));
         ram_ready <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            mem_rdata     <= mem_wdata;
         end else begin
            mem_rdata     <= ram[mem_addr];
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      int         due;
      logic       owner;
      logic [7:0] data;
   } exp_rsp_t;

   logic [7:0] mdl_mem [0:65535];
   exp_rsp_t   rsp_q[$];
   int         cyc;
   int         starve_m;
   logic       exp_en, exp_we;
   logic [15:0] exp_addr;
   logic [7:0] exp_wd, last_d, last_g;
   logic       obs_dg, obs_gg, obs_drv;
   logic [7:0] obs_drd;

   task automatic model_reset();
      rsp_q.delete();
      starve_m = 0;
      exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
      last_d = '0; last_g = '0;
   endtask

   // One clock cycle: drive, check at the falling edge, then advance the model.
   task automatic step(input logic dr, input logic [15:0] da, input logic gr,
                       input logic gw, input logic [15:0] ga, input logic [7:0] gd);
      logic exp_dg, exp_gg, starved;
      logic exp_drv, exp_grv;
      logic [7:0] exp_drd, exp_grd;
      exp_rsp_t r;
      disp_req = dr; disp_addr = da;
      game_req = gr; game_we = gw; game_addr = ga; game_wdata = gd;
      @(negedge clk);
      // Display has priority unless the game has already waited LIMIT cycles.
      starved = gr && (starve_m >= LIMIT);
      exp_gg  = gr && (starved || !dr);
      exp_dg  = dr && !exp_gg;
      check_eq("disp_gnt",  32'(disp_gnt),  32'(exp_dg));
      check_eq("game_gnt",  32'(game_gnt),  32'(exp_gg));
      check_eq("mem_en",    32'(mem_en),    32'(exp_en));
      check_eq("mem_we",    32'(mem_we),    32'(exp_we));
      check_eq("mem_addr",  32'(mem_addr),  32'(exp_addr));
      check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
      exp_drv = 1'b0; exp_grv = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
         r = rsp_q.pop_front();
         if (r.owner) begin exp_grv = 1'b1; last_g = r.data; end
         else         begin exp_drv = 1'b1; last_d = r.data; end
      end
      exp_drd = last_d; exp_grd = last_g;
      check_eq("disp_rvalid", 32'(disp_rvalid), 32'(exp_drv));
      check_eq("disp_rdata",  32'(disp_rdata),  32'(exp_drd));
      check_eq("game_rvalid", 32'(game_rvalid), 32'(exp_grv));
      check_eq("game_rdata",  32'(game_rdata),  32'(exp_grd));
      obs_dg = disp_gnt; obs_gg = game_gnt; obs_drv = disp_rvalid; obs_drd = disp_rdata;
      if (!gr || exp_gg) starve_m = 0;
      else if (starve_m < 255) starve_m++;
      exp_en = exp_dg || exp_gg;
      exp_we = exp_gg && gw;
      if (exp_gg) begin exp_addr = ga; exp_wd = gd; end
      else if (exp_dg) exp_addr = da;
      if (exp_dg || (exp_gg && !gw)) begin
         r.due = cyc + 2; r.owner = exp_gg; r.data = mdl_mem[exp_gg ? ga : da];
         rsp_q.push_back(r);
      end
      if (exp_gg && gw) mdl_mem[ga] = gd;
      cyc++;
      @(posedge clk); #1;
   endtask

   task automatic apply_reset(input logic hold_disp);
      disp_req = hold_disp; disp_addr = 16'h0033;
      game_req = hold_disp; game_we = 1'b0; game_addr = 16'h0044; game_wdata = 8'h00;
      reset_n = 1'b0;
      #1;
      check_eq("rst_disp_gnt",    32'(disp_gnt),    32'd0);
      check_eq("rst_game_gnt",    32'(game_gnt),    32'd0);
      check_eq("rst_mem_en",      32'(mem_en),      32'd0);
      check_eq("rst_mem_we",      32'(mem_we),      32'd0);
      check_eq("rst_mem_addr",    32'(mem_addr),    32'd0);
      check_eq("rst_mem_wdata",   32'(mem_wdata),   32'd0);
      check_eq("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
      check_eq("rst_disp_rdata",  32'(disp_rdata),  32'd0);
      check_eq("rst_game_rvalid", 32'(game_rvalid), 32'd0);
      check_eq("rst_game_rdata",  32'(game_rdata),  32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      disp_req = 1'b0; game_req = 1'b0;
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        d_pend, g_pend, g_w;
      logic [15:0] d_a, g_a;
      logic [7:0]  g_d;
      for (int i = 0; i < 65536; i++) mdl_mem[i] = mem_init(16'(i));
      cyc = 0;
      reset_n = 1'b1;
      disp_req = 1'b0; disp_addr = '0;
      game_req = 1'b0; game_we = 1'b0; game_addr = '0; game_wdata = '0;
      #2;
      apply_reset(1'b1);

      // Single display read of a preloaded word.
      step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 8'h00);
      check_eq("tp1_mem_en",   32'(mem_en),   32'd1);
      check_eq("tp1_mem_addr", 32'(mem_addr), 32'h0010);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
      check_eq("tp1_rvalid",      32'(disp_rvalid), 32'd1);
      check_eq("tp1_rdata",       32'(disp_rdata),  32'hA5);
      check_eq("tp1_game_rvalid", 32'(game_rvalid), 32'd0);

      // Game write then read-after-write to the same address.
      step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 8'h3C);
      check_eq("tp2_mem_we",    32'(mem_we),    32'd1);
      check_eq("tp2_mem_wdata", 32'(mem_wdata), 32'h3C);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 8'h00);
      check_eq("tp2_wr_no_rvalid", 32'(game_rvalid), 32'd0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
      check_eq("tp2_rd_rvalid", 32'(game_rvalid), 32'd1);
      check_eq("tp2_rd_rdata",  32'(game_rdata),  32'h3C);

      // Both clients saturating: game wins once per LIMIT+1 cycles.
      d_a = 16'h0040; g_a = 16'h0080;
      for (int i = 0; i < 3 * (LIMIT + 1); i++) begin
         step(1'b1, d_a, 1'b1, 1'b0, g_a, 8'h00);
         check_eq("starve_disp_gnt", 32'(obs_dg), 32'((i % (LIMIT + 1)) != LIMIT));
         check_eq("starve_game_gnt", 32'(obs_gg), 32'((i % (LIMIT + 1)) == LIMIT));
         if (obs_dg) d_a = 16'h0040 + 16'(i % 8);
         if (obs_gg) g_a = g_a + 16'd1;
      end

      // Back-to-back display reads of 0..7 come back as an unbroken burst.
      for (int k = 0; k < 10; k++) begin
         step(k < 8, 16'(k), 1'b0, 1'b0, 16'h0000, 8'h00);
         if (k >= 2) begin
            check_eq("burst_rvalid", 32'(obs_drv), 32'd1);
            check_eq("burst_rdata",  32'(obs_drd), 32'(mem_init(16'(k - 2))));
         end
      end

      // Idle: nothing issued, address holds the last granted one.
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
         check_eq("idle_mem_en",   32'(mem_en),   32'd0);
         check_eq("idle_mem_addr", 32'(mem_addr), 32'h0007);
      end

      // Reset one cycle after a display grant aborts the in-flight read.
      step(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 8'h00);
      apply_reset(1'b1);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
         check_eq("abort_no_rvalid", 32'(obs_drv), 32'd0);
      end

      // Random clients that hold requests until granted, occasionally giving up.
      d_pend = 1'b0; g_pend = 1'b0; d_a = '0; g_a = '0; g_w = 1'b0; g_d = '0;
      for (int i = 0; i < 3000; i++) begin
         if (d_pend && $urandom_range(0, 31) == 0) d_pend = 1'b0;
         if (g_pend && $urandom_range(0, 63) == 0) g_pend = 1'b0;
         if (!d_pend && $urandom_range(0, 3) != 0) begin
            d_pend = 1'b1; d_a = 16'($urandom_range(0, 15));
         end
         if (!g_pend && $urandom_range(0, 2) == 0) begin
            g_pend = 1'b1; g_a = 16'($urandom_range(0, 15));
            g_w = 1'($urandom_range(0, 1)); g_d = 8'($urandom);
         end
         step(d_pend, d_a, g_pend, g_w, g_a, g_d);
         if (obs_dg) d_pend = 1'b0;
         if (obs_gg) g_pend = 1'b0;
      end
      for (int k = 0; k < 3; k++) step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
      check_eq("drain_queue_empty", 32'(rsp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
